// File: rtl/baud_tick_gen_mc_if.sv
// Divisor configuration channel for baud_tick_gen_mc: write request, channel select,
// divisor value, plus the ready/error responses from the generator.
interface baud_tick_gen_mc_if #(
    parameter int NUM_CH = 2,
    parameter int INT_W  = 16,
    parameter int FRAC_W = 4
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic                    cfg_valid;
    logic                    cfg_ready;
    logic [CH_W-1:0]         cfg_ch;
    logic [INT_W+FRAC_W-1:0] cfg_div;
    logic                    cfg_err;

    modport master (
        output cfg_valid, cfg_ch, cfg_div,
        input  cfg_ready, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_div,
        output cfg_ready, cfg_err
    );
endinterface

// File: rtl/baud_tick_gen_mc.sv
// Multi-channel fractional baud tick generator: per-channel down-counter with a
// fractional carry accumulator, oversample counter, and shadowed divisor updates.
module baud_tick_gen_mc #(
    parameter int NUM_CH = 2,
    parameter int INT_W  = 16,
    parameter int FRAC_W = 4,
    parameter int OS     = 16,
    parameter logic [INT_W+FRAC_W-1:0] DEFAULT_DIV = {16'd325, 4'd8}
) (
    input  logic                             clk,
    input  logic                             rst,
    baud_tick_gen_mc_if.slave                cfg,
    input  logic [NUM_CH-1:0]                ch_en,
    input  logic [NUM_CH-1:0]                ch_idle,
    output logic [NUM_CH-1:0]                os_tick,
    output logic [NUM_CH-1:0]                baud_tick,
    output logic [NUM_CH-1:0]                pending,
    output logic [NUM_CH*(INT_W+FRAC_W)-1:0] active_div
);
    localparam int DIV_W = INT_W + FRAC_W;
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int OS_W  = $clog2(OS);
    localparam logic [INT_W-1:0] DEF_INT  = DEFAULT_DIV[DIV_W-1:FRAC_W];
    localparam logic [CH_W:0]    NUM_CH_L = (CH_W+1)'(NUM_CH);

    logic [DIV_W-1:0]  act_q    [NUM_CH];
    logic [DIV_W-1:0]  act_d    [NUM_CH];
    logic [DIV_W-1:0]  shadow_q [NUM_CH];
    logic [DIV_W-1:0]  shadow_d [NUM_CH];
    logic [INT_W-1:0]  cnt_q    [NUM_CH];
    logic [INT_W-1:0]  cnt_d    [NUM_CH];
    logic [FRAC_W-1:0] acc_q    [NUM_CH];
    logic [FRAC_W-1:0] acc_d    [NUM_CH];
    logic [OS_W-1:0]   osc_q    [NUM_CH];
    logic [OS_W-1:0]   osc_d    [NUM_CH];
    logic [NUM_CH-1:0] pend_q, pend_d;
    logic              err_q, err_d;

    logic pend_sel, cfg_rdy, wr_ok, wr_bad;

    always_comb begin
        logic [FRAC_W:0]  sum;
        logic [INT_W-1:0] cur_int;
        logic [INT_W-1:0] new_int;
        logic             apply;
        sum      = '0;
        cur_int  = '0;
        new_int  = '0;
        apply    = 1'b0;
        pend_sel = 1'b0;
        pend_d   = pend_q;
        os_tick  = '0;
        baud_tick = '0;
        active_div = '0;

        for (int c = 0; c < NUM_CH; c++) begin
            if (cfg.cfg_ch == CH_W'(c)) pend_sel = pend_q[c];
        end
        cfg_rdy = ~rst & ~pend_sel;
        wr_ok   = cfg.cfg_valid & cfg_rdy;
        wr_bad  = (cfg.cfg_div[DIV_W-1:FRAC_W] < INT_W'(2)) | ({1'b0, cfg.cfg_ch} >= NUM_CH_L);
        err_d   = wr_ok & wr_bad;

        for (int c = 0; c < NUM_CH; c++) begin
            act_d[c]    = act_q[c];
            shadow_d[c] = shadow_q[c];
            cnt_d[c]    = cnt_q[c];
            acc_d[c]    = acc_q[c];
            osc_d[c]    = osc_q[c];
            active_div[c*DIV_W +: DIV_W] = act_q[c];

            os_tick[c]   = ~rst & ch_en[c] & (cnt_q[c] == '0);
            baud_tick[c] = os_tick[c] & (osc_q[c] == OS_W'(OS-1));

            cur_int = act_q[c][DIV_W-1:FRAC_W];
            apply   = pend_q[c] & (ch_idle[c] | ~ch_en[c]);

            // A tick coincident with an apply still fires; the restart follows it.
            if (apply) begin
                act_d[c]  = shadow_q[c];
                pend_d[c] = 1'b0;
                new_int   = shadow_q[c][DIV_W-1:FRAC_W];
                cnt_d[c]  = new_int - INT_W'(1);
                acc_d[c]  = '0;
                osc_d[c]  = '0;
            end else if (!ch_en[c]) begin
                cnt_d[c] = cur_int - INT_W'(1);
                acc_d[c] = '0;
                osc_d[c] = '0;
            end else if (os_tick[c]) begin
                sum      = {1'b0, acc_q[c]} + {1'b0, act_q[c][FRAC_W-1:0]};
                acc_d[c] = sum[FRAC_W-1:0];
                cnt_d[c] = sum[FRAC_W] ? cur_int : (cur_int - INT_W'(1));
                osc_d[c] = osc_q[c] + OS_W'(1);
            end else begin
                cnt_d[c] = cnt_q[c] - INT_W'(1);
            end

            // Ready implies this channel had nothing pending, so no clash with apply.
            if (wr_ok && !wr_bad && (cfg.cfg_ch == CH_W'(c))) begin
                shadow_d[c] = cfg.cfg_div;
                pend_d[c]   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                act_q[c]    <= DEFAULT_DIV;
                shadow_q[c] <= DEFAULT_DIV;
                cnt_q[c]    <= DEF_INT - INT_W'(1);
                acc_q[c]    <= '0;
                osc_q[c]    <= '0;
            end
            pend_q <= '0;
            err_q  <= 1'b0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                act_q[c]    <= act_d[c];
                shadow_q[c] <= shadow_d[c];
                cnt_q[c]    <= cnt_d[c];
                acc_q[c]    <= acc_d[c];
                osc_q[c]    <= osc_d[c];
            end
            pend_q <= pend_d;
            err_q  <= err_d;
        end
    end

    assign pending       = pend_q;
    assign cfg.cfg_ready = cfg_rdy;
    assign cfg.cfg_err   = err_q;
endmodule

// File: tb/tb_baud_tick_gen_mc.sv
// Randomized and directed bench for baud_tick_gen_mc with a closed-form tick-time model.
module tb_baud_tick_gen_mc;
    localparam int NUM_CH = 3;
    localparam int INT_W  = 16;
    localparam int FRAC_W = 4;
    localparam int OS     = 16;
    localparam int DIV_W  = INT_W + FRAC_W;
    localparam logic [DIV_W-1:0] DEF = {16'd4, 4'd0};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NUM_CH-1:0] ch_en, ch_idle;
    wire  [NUM_CH-1:0] os_tick, baud_tick, pending;
    wire  [NUM_CH*DIV_W-1:0] active_div;

    baud_tick_gen_mc_if #(.NUM_CH(NUM_CH), .INT_W(INT_W), .FRAC_W(FRAC_W)) cfg_if ();

    baud_tick_gen_mc #(
        .NUM_CH(NUM_CH), .INT_W(INT_W), .FRAC_W(FRAC_W), .OS(OS), .DEFAULT_DIV(DEF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg        (cfg_if.slave),
        .ch_en      (ch_en),
        .ch_idle    (ch_idle),
        .os_tick    (os_tick),
        .baud_tick  (baud_tick),
        .pending    (pending),
        .active_div (active_div)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit chk_on = 1'b0;

    // Model: per channel, the current cycle index since restart (1-based) and the
    // number of the next expected oversample tick; tick n lands on cycle
    // n*int + floor((n-1)*frac / 2^FRAC_W).
    logic [DIV_W-1:0] m_act [NUM_CH];
    logic [DIV_W-1:0] m_sh  [NUM_CH];
    bit               m_pend [4];
    longint           m_e [NUM_CH];
    longint           m_n [NUM_CH];
    bit               m_err;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails <= 30) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint t_of(input int c, input longint n);
        longint ai, af;
        ai = longint'(m_act[c][DIV_W-1:FRAC_W]);
        af = longint'(m_act[c][FRAC_W-1:0]);
        return n * ai + ((n - 1) * af) / (longint'(1) << FRAC_W);
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_act[c] = DEF;
            m_sh[c]  = DEF;
            m_e[c]   = 1;
            m_n[c]   = 1;
        end
        for (int c = 0; c < 4; c++) m_pend[c] = 1'b0;
        m_err = 1'b0;
    endtask

    initial model_reset();

    always @(negedge clk) begin
        logic [NUM_CH-1:0]       e_os, e_bd, e_pd;
        logic [NUM_CH*DIV_W-1:0] e_act;
        logic                    e_rdy, wr, bad;
        for (int c = 0; c < NUM_CH; c++) begin
            e_os[c] = !rst && ch_en[c] && (m_e[c] == t_of(c, m_n[c]));
            e_bd[c] = e_os[c] && (m_n[c] % OS == 0);
            e_pd[c] = m_pend[c];
            e_act[c*DIV_W +: DIV_W] = m_act[c];
        end
        e_rdy = !rst && !m_pend[cfg_if.cfg_ch];
        if (chk_on) begin
            check("os_tick",    64'(os_tick),          64'(e_os));
            check("baud_tick",  64'(baud_tick),        64'(e_bd));
            check("pending",    64'(pending),          64'(e_pd));
            check("active_div", 64'(active_div),       64'(e_act));
            check("cfg_ready",  64'(cfg_if.cfg_ready), 64'(e_rdy));
            check("cfg_err",    64'(cfg_if.cfg_err),   64'(m_err));
        end
        if (rst) begin
            model_reset();
        end else begin
            wr  = cfg_if.cfg_valid && e_rdy;
            bad = (cfg_if.cfg_div[DIV_W-1:FRAC_W] < 2) || (cfg_if.cfg_ch >= NUM_CH);
            for (int c = 0; c < NUM_CH; c++) begin
                if (m_pend[c] && (ch_idle[c] || !ch_en[c])) begin
                    m_act[c] = m_sh[c];
                    m_pend[c] = 1'b0;
                    m_e[c] = 1;
                    m_n[c] = 1;
                end else if (!ch_en[c]) begin
                    m_e[c] = 1;
                    m_n[c] = 1;
                end else begin
                    if (e_os[c]) m_n[c]++;
                    m_e[c]++;
                end
            end
            m_err = wr && bad;
            if (wr && !bad) begin
                m_sh[cfg_if.cfg_ch]   = cfg_if.cfg_div;
                m_pend[cfg_if.cfg_ch] = 1'b1;
            end
        end
    end

    task automatic count_win(input int n, input int c, output int nos, output int nb, output int first);
        nos = 0; nb = 0; first = 0;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            if (os_tick[c]) begin
                nos++;
                if (first == 0) first = i;
            end
            if (baud_tick[c]) nb++;
        end
        @(posedge clk); #1;
    endtask

    task automatic write_cfg(input int c, input logic [DIV_W-1:0] d);
        logic [1:0] cs;
        cs = c[1:0];
        cfg_if.cfg_ch    = cs;
        cfg_if.cfg_div   = d;
        cfg_if.cfg_valid = 1'b1;
        @(posedge clk); #1;
        cfg_if.cfg_valid = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nos, nb, first;
        ch_en = 3'b001;
        ch_idle = 3'b111;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_ch = '0;
        cfg_if.cfg_div = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk_on = 1'b1;

        // Default divisor 4.0: ticks on cycles 4,8,..,64; baud on the 16th.
        check("rst_pending", 64'(pending), 64'(0));
        check("rst_active0", 64'(active_div[19:0]), 64'(20'h00040));
        count_win(64, 0, nos, nb, first);
        check("def_first_os", 64'(first), 64'(4));
        check("def_os_cnt", 64'(nos), 64'(16));
        check("def_baud_cnt", 64'(nb), 64'(1));

        // Divisor 4.5 applied while idle.
        write_cfg(0, {16'd4, 4'd8});
        check("frac_pending", 64'(pending[0]), 64'(1));
        @(posedge clk); #1;
        check("frac_active", 64'(active_div[19:0]), 64'(20'h00048));
        count_win(72, 0, nos, nb, first);
        check("frac_first_os", 64'(first), 64'(4));
        check("frac_os_cnt", 64'(nos), 64'(16));
        check("frac_baud_cnt", 64'(nb), 64'(1));

        // Busy channel holds the new divisor until idle.
        ch_idle[0] = 1'b0;
        write_cfg(0, {16'd10, 4'd0});
        check("busy_pending", 64'(pending[0]), 64'(1));
        check("busy_ready", 64'(cfg_if.cfg_ready), 64'(0));
        count_win(30, 0, nos, nb, first);
        check("busy_active_old", 64'(active_div[19:0]), 64'(20'h00048));
        ch_idle[0] = 1'b1;
        @(posedge clk); #1;
        check("apply_active", 64'(active_div[19:0]), 64'(20'h000A0));
        check("apply_pending", 64'(pending[0]), 64'(0));
        count_win(20, 0, nos, nb, first);
        check("apply_first_os", 64'(first), 64'(10));
        check("apply_os_cnt", 64'(nos), 64'(2));

        // Rejected writes: integer part 1, then out-of-range channel.
        write_cfg(0, {16'd1, 4'd0});
        check("rej_int_err", 64'(cfg_if.cfg_err), 64'(1));
        @(posedge clk); #1;
        check("rej_int_err_end", 64'(cfg_if.cfg_err), 64'(0));
        check("rej_int_active", 64'(active_div[19:0]), 64'(20'h000A0));
        check("rej_int_pending", 64'(pending), 64'(0));
        write_cfg(3, {16'd5, 4'd0});
        check("rej_ch_err", 64'(cfg_if.cfg_err), 64'(1));
        @(posedge clk); #1;
        check("rej_ch_err_end", 64'(cfg_if.cfg_err), 64'(0));
        check("rej_ch_pending", 64'(pending), 64'(0));

        // ch0 at 4, ch1 at 6; pause ch1 and resume.
        write_cfg(0, {16'd4, 4'd0});
        @(posedge clk); #1;
        write_cfg(1, {16'd6, 4'd0});
        ch_en = 3'b011;
        @(posedge clk); #1;
        count_win(40, 1, nos, nb, first);
        check("ch1_first_os", 64'(first), 64'(6));
        check("ch1_os_cnt", 64'(nos), 64'(6));
        ch_en[1] = 1'b0;
        count_win(20, 1, nos, nb, first);
        check("ch1_off_os_cnt", 64'(nos), 64'(0));
        ch_en[1] = 1'b1;
        count_win(12, 1, nos, nb, first);
        check("ch1_resume_first", 64'(first), 64'(6));
        check("ch1_resume_cnt", 64'(nos), 64'(2));

        // Reset discards a pending write.
        ch_idle[0] = 1'b0;
        write_cfg(0, {16'd8, 4'd0});
        check("prerst_pending", 64'(pending[0]), 64'(1));
        rst = 1'b1;
        @(negedge clk);
        check("inrst_os", 64'(os_tick), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        check("postrst_pending", 64'(pending), 64'(0));
        check("postrst_active", 64'(active_div), 64'({DEF, DEF, DEF}));
        @(negedge clk);
        check("postrst_os", 64'(os_tick), 64'(0));
        check("postrst_baud", 64'(baud_tick), 64'(0));
        @(posedge clk); #1;
        ch_idle[0] = 1'b1;

        // Randomized traffic, checked every cycle by the model.
        for (int i = 0; i < 3000; i++) begin
            logic [15:0] ri;
            logic [3:0]  rf;
            ri = 16'($urandom_range(0, 12));
            rf = 4'($urandom);
            cfg_if.cfg_valid = ($urandom % 6 == 0);
            cfg_if.cfg_ch    = 2'($urandom);
            cfg_if.cfg_div   = {ri, rf};
            if ($urandom % 40 == 0) ch_en = 3'($urandom);
            ch_idle = 3'($urandom);
            rst = ($urandom % 700 == 0);
            @(posedge clk); #1;
        end
        rst = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
